// File: rtl/coeff_update_seq_if.sv
// Request/response bundle for coeff_update_seq: operand banks and k in,
// committed coefficient bank out, with a valid/ready accept handshake.
interface coeff_update_seq_if #(
  parameter int ORDER = 10,
  parameter int IN_W  = 32,
  parameter int K_W   = 16,
  parameter int OUT_W = 16
);
  logic [(ORDER+1)*IN_W-1:0]  aL_flat;
  logic [(ORDER+1)*IN_W-1:0]  aR_flat;
  logic [K_W-1:0]             k;
  logic                       v;
  logic                       ready;
  logic [(ORDER+1)*OUT_W-1:0] a_next_flat;
  logic                       vout;
  logic                       sat;

  modport master (
    output aL_flat, aR_flat, k, v,
    input  ready, a_next_flat, vout, sat
  );

  modport slave (
    input  aL_flat, aR_flat, k, v,
    output ready, a_next_flat, vout, sat
  );
endinterface

// File: rtl/coeff_update_seq.sv
// Time-multiplexed Levinson-Durbin update a_next[i] = round(aL[i] + aR[i]*k),
// one shared multiplier, two-stage pipeline, atomic commit of the whole bank.
module coeff_update_seq #(
  parameter int ORDER = 10,
  parameter int IN_W  = 32,
  parameter int K_W   = 16,
  parameter int OUT_W = 16,
  parameter int FRAC  = 15,
  parameter int SAT   = 1
) (
  input  logic               clk,
  input  logic               rst,
  coeff_update_seq_if.slave  bus
);

  localparam int N     = ORDER + 1;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int PW    = IN_W + K_W;
  localparam int SW    = PW + 1;

  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(ORDER);
  localparam logic signed [SW-1:0] RND     = {{(SW-1){1'b0}}, 1'b1} << (FRAC-1);
  localparam logic signed [SW-1:0] MAX_V   = {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SW-1:0] MIN_V   = ~MAX_V;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t                    state_q,   state_d;
  logic [IDX_W-1:0]          idx_q,     idx_d;
  logic                      drain_q,   drain_d;
  logic                      p_vld_q,   p_vld_d;
  logic                      sat_acc_q, sat_acc_d;
  logic                      sat_q,     sat_d;
  logic                      vout_q,    vout_d;
  logic [OUT_W-1:0]          a_next_q [N];
  logic [OUT_W-1:0]          a_next_d [N];

  logic signed [IN_W-1:0]    al_q [N];
  logic signed [IN_W-1:0]    al_d [N];
  logic signed [IN_W-1:0]    ar_q [N];
  logic signed [IN_W-1:0]    ar_d [N];
  logic signed [K_W-1:0]     k_q,       k_d;
  logic signed [PW-1:0]      p_q,       p_d;
  logic [IDX_W-1:0]          p_idx_q,   p_idx_d;
  logic [OUT_W-1:0]          bank_q [N];
  logic [OUT_W-1:0]          bank_d [N];

  logic signed [PW-1:0]      ar_ext, k_ext;
  logic signed [SW-1:0]      al_ext, p_ext, s_sum, r_shift;
  logic [OUT_W-1:0]          res;
  logic                      clamp;

  // Stage 2: full-width sum, round-half-up, arithmetic shift, optional clamp.
  always_comb begin
    al_ext  = {{(SW-IN_W){al_q[p_idx_q][IN_W-1]}}, al_q[p_idx_q]};
    p_ext   = {p_q[PW-1], p_q};
    s_sum   = (al_ext <<< FRAC) + p_ext + RND;
    r_shift = s_sum >>> FRAC;
    res     = r_shift[OUT_W-1:0];
    clamp   = 1'b0;
    if (SAT != 0) begin
      if (r_shift > MAX_V) begin
        res   = MAX_V[OUT_W-1:0];
        clamp = 1'b1;
      end else if (r_shift < MIN_V) begin
        res   = MIN_V[OUT_W-1:0];
        clamp = 1'b1;
      end
    end
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; a missing default here would infer a latch.
    state_d   = state_q;
    idx_d     = idx_q;
    drain_d   = drain_q;
    p_vld_d   = 1'b0;
    sat_acc_d = sat_acc_q;
    sat_d     = sat_q;
    vout_d    = 1'b0;
    a_next_d  = a_next_q;
    al_d      = al_q;
    ar_d      = ar_q;
    k_d       = k_q;
    p_d       = p_q;
    p_idx_d   = p_idx_q;
    bank_d    = bank_q;

    ar_ext = {{(PW-IN_W){ar_q[idx_q][IN_W-1]}}, ar_q[idx_q]};
    k_ext  = {{(PW-K_W){k_q[K_W-1]}}, k_q};

    unique case (state_q)
      S_IDLE: begin
        if (bus.v) begin
          for (int i = 0; i < N; i++) begin
            al_d[i] = bus.aL_flat[i*IN_W +: IN_W];
            ar_d[i] = bus.aR_flat[i*IN_W +: IN_W];
          end
          k_d       = bus.k;
          idx_d     = '0;
          sat_acc_d = 1'b0;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        p_d     = ar_ext * k_ext;
        p_idx_d = idx_q;
        p_vld_d = 1'b1;
        if (idx_q == LAST_IDX) begin
          drain_d = 1'b0;
          state_d = S_DRAIN;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_DRAIN: begin
        // Second drain cycle: the last tap landed in bank_q on the previous edge.
        if (drain_q) begin
          a_next_d = bank_q;
          sat_d    = sat_acc_q;
          vout_d   = 1'b1;
          state_d  = S_IDLE;
        end else begin
          drain_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (p_vld_q) begin
      bank_d[p_idx_q] = res;
      if (clamp) sat_acc_d = 1'b1;
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      drain_q   <= 1'b0;
      p_vld_q   <= 1'b0;
      sat_acc_q <= 1'b0;
      sat_q     <= 1'b0;
      vout_q    <= 1'b0;
      a_next_q  <= '{default: '0};
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      drain_q   <= drain_d;
      p_vld_q   <= p_vld_d;
      sat_acc_q <= sat_acc_d;
      sat_q     <= sat_d;
      vout_q    <= vout_d;
      a_next_q  <= a_next_d;
    end
  end

  // NOTE: operand latches and the result bank carry no reset; they are always
  // rewritten after an accept before anything reads them.
  always_ff @(posedge clk) begin
    al_q    <= al_d;
    ar_q    <= ar_d;
    k_q     <= k_d;
    p_q     <= p_d;
    p_idx_q <= p_idx_d;
    bank_q  <= bank_d;
  end

  always_comb begin
    bus.a_next_flat = '0;
    for (int i = 0; i < N; i++) begin
      bus.a_next_flat[i*OUT_W +: OUT_W] = a_next_q[i];
    end
  end

  assign bus.ready = (state_q == S_IDLE);
  assign bus.vout  = vout_q;
  assign bus.sat   = sat_q;

endmodule

// File: tb/tb_coeff_update_seq.sv
// Directed bench for coeff_update_seq: an ORDER=10 saturating instance and an
// ORDER=2 wrapping instance, with hand-computed expected banks.
module tb_coeff_update_seq;

  localparam int IN_W  = 32;
  localparam int K_W   = 16;
  localparam int OUT_W = 16;
  localparam int FRAC  = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  coeff_update_seq_if #(.ORDER(10), .IN_W(IN_W), .K_W(K_W), .OUT_W(OUT_W)) if10 ();
  coeff_update_seq_if #(.ORDER(2),  .IN_W(IN_W), .K_W(K_W), .OUT_W(OUT_W)) if2  ();

  coeff_update_seq #(
    .ORDER(10), .IN_W(IN_W), .K_W(K_W), .OUT_W(OUT_W), .FRAC(FRAC), .SAT(1)
  ) dut10 (
    .clk (clk),
    .rst (rst),
    .bus (if10)
  );

  coeff_update_seq #(
    .ORDER(2), .IN_W(IN_W), .K_W(K_W), .OUT_W(OUT_W), .FRAC(FRAC), .SAT(0)
  ) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (if2)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic signed [31:0] al10 [11];
  logic signed [31:0] ar10 [11];
  logic signed [15:0] exp10 [11];
  logic signed [31:0] al2 [3];
  logic signed [31:0] ar2 [3];

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [15:0] out10(input int i);
    return if10.a_next_flat[i*OUT_W +: OUT_W];
  endfunction

  function automatic logic signed [15:0] out2(input int i);
    return if2.a_next_flat[i*OUT_W +: OUT_W];
  endfunction

  task automatic pack10(input logic [15:0] kk, input logic vv);
    for (int i = 0; i < 11; i++) begin
      if10.aL_flat[i*IN_W +: IN_W] = al10[i];
      if10.aR_flat[i*IN_W +: IN_W] = ar10[i];
    end
    if10.k = kk;
    if10.v = vv;
  endtask

  // Called at a negedge with the DUT idle; returns in the vout cycle.
  task automatic run10(input string tag, input logic [15:0] kk);
    int lat;
    pack10(kk, 1'b1);
    @(negedge clk);
    if10.v = 1'b0;
    check({tag, "_busy"}, if10.ready, 0);
    lat = 0;
    while (if10.vout !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (if10.vout !== 1'b1) lat = -1;
    check({tag, "_lat"}, lat, 13);
    check({tag, "_rdy"}, if10.ready, 1);
  endtask

  task automatic check_bank10(input string tag);
    for (int i = 0; i < 11; i++)
      check($sformatf("%s_a%0d", tag, i), out10(i), exp10[i]);
  endtask

  int acc_q [$];
  int acc_c;
  int vcount;
  int vhits;
  int lat2;
  logic prev_vout;

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 11; i++) begin
      al10[i] = '0;
      ar10[i] = '0;
    end
    pack10(16'h0, 1'b0);
    if2.aL_flat = '0;
    if2.aR_flat = '0;
    if2.k       = '0;
    if2.v       = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", if10.ready, 1);
    check("rst_vout", if10.vout, 0);
    check("rst_sat", if10.sat, 0);
    check("rst_flat", (if10.a_next_flat == '0), 1);
    check("rst_flat2", (if2.a_next_flat == '0), 1);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", if10.ready, 1);

    // T1 basic: aL=1000*i, aR=2000, k=0.5 -> 1000*(i+1)
    for (int i = 0; i < 11; i++) begin
      al10[i]  = 1000 * i;
      ar10[i]  = 2000;
      exp10[i] = 16'(1000 * (i + 1));
    end
    run10("t1", 16'h4000);
    check_bank10("t1");
    check("t1_sat", if10.sat, 0);
    @(negedge clk);
    check("t1_pulse", if10.vout, 0);
    check("t1_hold", out10(10), 11000);

    // T3a positive clamp on tap 3
    for (int i = 0; i < 11; i++) begin
      al10[i]  = 10 * i;
      ar10[i]  = 0;
      exp10[i] = 16'(10 * i);
    end
    al10[3] = 30000; ar10[3] = 30000; exp10[3] = 16'sd32767;
    run10("t3a", 16'h7FFF);
    check_bank10("t3a");
    check("t3a_sat", if10.sat, 1);
    @(negedge clk);

    // T3b negative clamp on tap 4
    al10[3] = 30;  ar10[3] = 0;  exp10[3] = 16'sd30;
    al10[4] = -30000; ar10[4] = 30000; exp10[4] = -16'sd32768;
    run10("t3b", 16'h8000);
    check_bank10("t3b");
    check("t3b_sat", if10.sat, 1);
    @(negedge clk);
    check("t3b_sat_hold", if10.sat, 1);

    // T2 rounding, ties go toward +inf; sat clears on a clean update
    for (int i = 0; i < 11; i++) begin
      al10[i]  = 0;
      ar10[i]  = 0;
      exp10[i] = 0;
    end
    ar10[0] = 1;  exp10[0] = 1;
    ar10[1] = -1; exp10[1] = 0;
    ar10[2] = -2; exp10[2] = -1;
    ar10[3] = 3;  exp10[3] = 2;
    run10("t2", 16'h4000);
    check_bank10("t2");
    check("t2_sat", if10.sat, 0);
    @(negedge clk);

    // T4 back-to-back: v held, data changes every cycle; result[i] = c*101 + i
    vcount    = 0;
    prev_vout = 1'b0;
    for (int c = 1; c < 80 && vcount < 3; c++) begin
      if (if10.vout === 1'b1) begin
        check("t4_pulse", prev_vout, 0);
        check("t4_rdy", if10.ready, 1);
        if (acc_q.size() > 0) begin
          acc_c = acc_q.pop_front();
          check("t4_lat", c - acc_c - 1, 13);
          for (int i = 0; i < 11; i++)
            check($sformatf("t4_a%0d", i), out10(i), acc_c * 101 + i);
        end else begin
          check("t4_orphan_vout", acc_q.size(), 1);
        end
        vcount++;
      end
      prev_vout = if10.vout;
      if (vcount == 3) break;
      for (int i = 0; i < 11; i++) begin
        al10[i] = c * 100 + i;
        ar10[i] = 2 * c;
      end
      pack10(16'h4000, 1'b1);
      if (if10.ready === 1'b1) acc_q.push_back(c);
      @(negedge clk);
    end
    check("t4_count", vcount, 3);
    if10.v = 1'b0;
    acc_q.delete();
    @(negedge clk);

    // T5 reset at RUN idx=5 aborts the update and zeroes the outputs
    for (int i = 0; i < 11; i++) begin
      al10[i]  = 1000 * i;
      ar10[i]  = 2000;
      exp10[i] = 16'(1000 * (i + 1));
    end
    pack10(16'h4000, 1'b1);
    @(negedge clk);
    if10.v = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_ready", if10.ready, 1);
    check("t5_vout", if10.vout, 0);
    check("t5_sat", if10.sat, 0);
    check("t5_flat", (if10.a_next_flat == '0), 1);
    vhits = 0;
    repeat (20) begin
      @(negedge clk);
      if (if10.vout === 1'b1) vhits++;
    end
    check("t5_no_vout", vhits, 0);
    run10("t5r", 16'h4000);
    check_bank10("t5r");
    @(negedge clk);

    // T6 wrap mode on ORDER=2: 40000 -> -25536, -5+2 -> -3, 100000 -> -31072
    al2[0] = 40000;  ar2[0] = 0;
    al2[1] = -5;     ar2[1] = 4;
    al2[2] = 100000; ar2[2] = 0;
    for (int i = 0; i < 3; i++) begin
      if2.aL_flat[i*IN_W +: IN_W] = al2[i];
      if2.aR_flat[i*IN_W +: IN_W] = ar2[i];
    end
    if2.k = 16'h4000;
    if2.v = 1'b1;
    @(negedge clk);
    if2.v = 1'b0;
    lat2 = 0;
    while (if2.vout !== 1'b1 && lat2 < 40) begin
      @(negedge clk);
      lat2++;
    end
    if (if2.vout !== 1'b1) lat2 = -1;
    check("t6_lat", lat2, 5);
    check("t6_a0", out2(0), -25536);
    check("t6_a1", out2(1), -3);
    check("t6_a2", out2(2), -31072);
    check("t6_sat", if2.sat, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
